// File: rtl/vga_dither_out.sv
// VGA output stage: reduces per-channel colour depth by truncation or 2x2 Bayer dithering,
// blanks outside the active area, and delays syncs to match. Free-running, one pixel per clock, no handshake.
module vga_dither_out #(
  parameter int IN_BITS         = 8,
  parameter int OUT_BITS        = 4,
  parameter int MODE            = 1,
  parameter int SYNC_ACTIVE_LOW = 1
) (
  input  logic                CLK_25MHZ,
  input  logic                RESET,
  input  logic                IN_HSYNC,
  input  logic                IN_VSYNC,
  input  logic                IN_DE,
  input  logic [IN_BITS-1:0]  IN_RED,
  input  logic [IN_BITS-1:0]  IN_GREEN,
  input  logic [IN_BITS-1:0]  IN_BLUE,
  output logic                VGA_HSYNC,
  output logic                VGA_VSYNC,
  output logic [OUT_BITS-1:0] VGA_RED,
  output logic [OUT_BITS-1:0] VGA_GREEN,
  output logic [OUT_BITS-1:0] VGA_BLUE
);

  localparam int   D   = IN_BITS - OUT_BITS;
  localparam int   SH  = (D >= 2) ? D - 2 : 0;
  localparam logic POL = (SYNC_ACTIVE_LOW != 0);

  // Syncs are carried internally as active-high so every register resets to 0
  // while the pins still come out of reset inactive.
  logic hs_act, vs_act;
  assign hs_act = IN_HSYNC ^ POL;
  assign vs_act = IN_VSYNC ^ POL;

  logic vs_prev, de_prev, xp, yp, fp;
  logic vs_edge, de_fall;
  assign vs_edge = vs_act & ~vs_prev;
  assign de_fall = de_prev & ~IN_DE;

  always_ff @(posedge CLK_25MHZ or posedge RESET) begin
    if (RESET) begin
      vs_prev <= 1'b0;
      de_prev <= 1'b0;
      xp      <= 1'b0;
      yp      <= 1'b0;
      fp      <= 1'b0;
    end else begin
      vs_prev <= vs_act;
      de_prev <= IN_DE;
      xp      <= IN_DE ? ~xp : 1'b0;
      // The vsync clear takes priority over a coincident DE falling edge.
      if (vs_edge) begin
        yp <= 1'b0;
        fp <= ~fp;
      end else if (de_fall) begin
        yp <= ~yp;
      end
    end
  end

  logic               xi;
  logic [1:0]         b;
  logic [IN_BITS-1:0] t;

  always_comb begin
    xi = (MODE == 2) ? (xp ^ fp) : xp;
    case ({yp, xi})
      2'b00:   b = 2'd0;
      2'b01:   b = 2'd2;
      2'b10:   b = 2'd3;
      default: b = 2'd1;
    endcase
    t = '0;
    if (MODE != 0 && D >= 2)
      t = IN_BITS'(b) << SH;
    else if (MODE != 0 && D == 1)
      t = IN_BITS'(b >> 1);
  end

  // Keeps only the bits stage 2 needs: overflow bit plus the OUT_BITS result.
  function automatic logic [OUT_BITS:0] add_top(input logic [IN_BITS-1:0] c,
                                                input logic [IN_BITS-1:0] th);
    logic [IN_BITS:0] s;
    s = {1'b0, c} + {1'b0, th};
    return (OUT_BITS+1)'(s >> D);
  endfunction

  function automatic logic [OUT_BITS-1:0] reduce(input logic [OUT_BITS:0] top);
    return top[OUT_BITS] ? {OUT_BITS{1'b1}} : top[OUT_BITS-1:0];
  endfunction

  logic [OUT_BITS:0] top_r, top_g, top_b;
  logic              de1, hs1, vs1, hs2, vs2;

  always_ff @(posedge CLK_25MHZ or posedge RESET) begin
    if (RESET) begin
      top_r <= '0;
      top_g <= '0;
      top_b <= '0;
      de1   <= 1'b0;
      hs1   <= 1'b0;
      vs1   <= 1'b0;
    end else begin
      top_r <= add_top(IN_RED, t);
      top_g <= add_top(IN_GREEN, t);
      top_b <= add_top(IN_BLUE, t);
      de1   <= IN_DE;
      hs1   <= hs_act;
      vs1   <= vs_act;
    end
  end

  always_ff @(posedge CLK_25MHZ or posedge RESET) begin
    if (RESET) begin
      VGA_RED   <= '0;
      VGA_GREEN <= '0;
      VGA_BLUE  <= '0;
      hs2       <= 1'b0;
      vs2       <= 1'b0;
    end else begin
      VGA_RED   <= de1 ? reduce(top_r) : '0;
      VGA_GREEN <= de1 ? reduce(top_g) : '0;
      VGA_BLUE  <= de1 ? reduce(top_b) : '0;
      hs2       <= hs1;
      vs2       <= vs1;
    end
  end

  assign VGA_HSYNC = hs2 ^ POL;
  assign VGA_VSYNC = vs2 ^ POL;

endmodule

// File: tb/tb_vga_dither_out.sv
// Directed bench for vga_dither_out: three instances (MODE 0/1/2) share one stimulus stream,
// each vector carries hand-computed outputs that are checked exactly two clocks later.
module tb_vga_dither_out;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_hs, in_vs, in_de;
  logic [7:0] in_r, in_g, in_b;

  logic       hs0, vs0, hs1, vs1, hs2, vs2;
  logic [3:0] r0, g0, b0, r1, g1, b1, r2, g2, b2;

  int errors = 0;
  int checks = 0;
  int vec_n  = 0;

  // Entry layout: {hsync, vsync, mode0 rgb, mode1 rgb, mode2 rgb}
  logic [37:0] exp_q[$];

  always #20 clk = ~clk;

  vga_dither_out #(.IN_BITS(8), .OUT_BITS(4), .MODE(0), .SYNC_ACTIVE_LOW(1)) u_m0 (
    .CLK_25MHZ(clk), .RESET(rst), .IN_HSYNC(in_hs), .IN_VSYNC(in_vs), .IN_DE(in_de),
    .IN_RED(in_r), .IN_GREEN(in_g), .IN_BLUE(in_b),
    .VGA_HSYNC(hs0), .VGA_VSYNC(vs0), .VGA_RED(r0), .VGA_GREEN(g0), .VGA_BLUE(b0)
  );

  vga_dither_out #(.IN_BITS(8), .OUT_BITS(4), .MODE(1), .SYNC_ACTIVE_LOW(1)) u_m1 (
    .CLK_25MHZ(clk), .RESET(rst), .IN_HSYNC(in_hs), .IN_VSYNC(in_vs), .IN_DE(in_de),
    .IN_RED(in_r), .IN_GREEN(in_g), .IN_BLUE(in_b),
    .VGA_HSYNC(hs1), .VGA_VSYNC(vs1), .VGA_RED(r1), .VGA_GREEN(g1), .VGA_BLUE(b1)
  );

  vga_dither_out #(.IN_BITS(8), .OUT_BITS(4), .MODE(2), .SYNC_ACTIVE_LOW(1)) u_m2 (
    .CLK_25MHZ(clk), .RESET(rst), .IN_HSYNC(in_hs), .IN_VSYNC(in_vs), .IN_DE(in_de),
    .IN_RED(in_r), .IN_GREEN(in_g), .IN_BLUE(in_b),
    .VGA_HSYNC(hs2), .VGA_VSYNC(vs2), .VGA_RED(r2), .VGA_GREEN(g2), .VGA_BLUE(b2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s (vec %0d): got %0h expected %0h", tag, vec_n, obs, exp);
    end
  endtask

  // Drive one pixel, clock it, then check the output belonging to the pixel two clocks back.
  task automatic pix(input logic hs, input logic vs, input logic de,
                     input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                     input logic [11:0] e0, input logic [11:0] e1, input logic [11:0] e2);
    logic [37:0] ent;
    in_hs = hs; in_vs = vs; in_de = de;
    in_r = r; in_g = g; in_b = b;
    exp_q.push_back({hs, vs, e0, e1, e2});
    @(posedge clk); #1;
    if (exp_q.size() >= 2) begin
      ent = exp_q.pop_front();
      vec_n++;
      check("sync",  32'({hs0, vs0, hs1, vs1, hs2, vs2}), 32'({3{ent[37:36]}}));
      check("mode0", 32'({r0, g0, b0}), 32'(ent[35:24]));
      check("mode1", 32'({r1, g1, b1}), 32'(ent[23:12]));
      check("mode2", 32'({r2, g2, b2}), 32'(ent[11:0]));
    end
  endtask

  // Visible 0x88 pixel: mode 0 always gives 8; d1/d2 are the mode 1/2 nibbles.
  task automatic px88(input logic [3:0] d1, input logic [3:0] d2);
    pix(1'b1, 1'b1, 1'b1, 8'h88, 8'h88, 8'h88, 12'h888, {3{d1}}, {3{d2}});
  endtask

  task automatic idle();
    pix(1'b1, 1'b1, 1'b0, 8'h88, 8'h88, 8'h88, 12'h000, 12'h000, 12'h000);
  endtask

  task automatic hpulse();
    pix(1'b0, 1'b1, 1'b0, 8'h88, 8'h88, 8'h88, 12'h000, 12'h000, 12'h000);
  endtask

  task automatic vpulse();
    pix(1'b1, 1'b0, 1'b0, 8'h88, 8'h88, 8'h88, 12'h000, 12'h000, 12'h000);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_col"}, 32'({r0, g0, b0, r1, g1, b1, r2, g2, b2}), 32'(0));
    check({tag, "_sync"}, 32'({hs0, vs0, hs1, vs1, hs2, vs2}), 32'(6'b111111));
  endtask

  initial begin
    rst = 1'b1;
    in_hs = 1'b1; in_vs = 1'b1; in_de = 1'b0;
    in_r = 8'h00; in_g = 8'h00; in_b = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset_init");
    exp_q.push_back({2'b11, 36'h0});
    rst = 1'b0;

    // Line before any vsync: fp = 0, leaves yp = 1 so the vsync clear is exercised.
    px88(4'h8, 4'h8); px88(4'h9, 4'h9); hpulse(); idle();

    // Frame 0: fp = 1 after the vsync edge.
    vpulse(); idle();
    px88(4'h8, 4'h9); px88(4'h9, 4'h8); hpulse(); idle();
    px88(4'h9, 4'h8); px88(4'h8, 4'h9); hpulse(); idle();

    // Frame 1: fp = 0, three rows so yp = 0 before the next vsync.
    vpulse(); idle();
    px88(4'h8, 4'h8); px88(4'h9, 4'h9); hpulse(); idle();
    px88(4'h9, 4'h9); px88(4'h8, 4'h8); hpulse(); idle();
    px88(4'h8, 4'h8); px88(4'h9, 4'h9);
    // DE falls in the same cycle as the vsync edge: yp must clear, not toggle.
    vpulse(); idle();

    // Frame 2: fp = 1 again, with saturation and per-channel vectors.
    px88(4'h8, 4'h9);
    pix(1'b1, 1'b1, 1'b1, 8'hF8, 8'h78, 8'h10, 12'hF71, 12'hF81, 12'hF71);
    hpulse(); idle();
    pix(1'b1, 1'b1, 1'b1, 8'hFF, 8'h00, 8'h88, 12'hF08, 12'hF09, 12'hF08);
    px88(4'h8, 4'h9);
    hpulse(); idle();

    // Active syncs and colour in flight, then an asynchronous mid-line reset.
    pix(1'b0, 1'b0, 1'b1, 8'h88, 8'h88, 8'h88, 12'h888, 12'h888, 12'h999);
    px88(4'h9, 4'h9);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("reset_mid");
    exp_q.delete();
    exp_q.push_back({2'b11, 36'h0});
    @(posedge clk); #1;
    rst = 1'b0;

    // Parities restart at 0 after reset.
    px88(4'h8, 4'h8); px88(4'h9, 4'h9); hpulse(); idle(); idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
